// File: rtl/pc_predict.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict
// Brief    : Fetch-stage program counter with stall hold, redirect override
//            and a direct-mapped BTB using 2-bit saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_predict #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    localparam logic [1:0] c_CTR_RESET = 2'b01;
    localparam logic [1:0] c_CTR_ALLOC = 2'b10;
    localparam logic [1:0] c_CTR_MAX   = 2'b11;
    localparam logic [1:0] c_CTR_MIN   = 2'b00;

    // PC is kept word-aligned: only bits [XLEN-1:2] are stored.
    logic [XLEN-3:0]     r_pc;

    logic                r_valid  [BTB_ENTRIES];
    logic [1:0]          r_ctr    [BTB_ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-3:0]     r_target [BTB_ENTRIES];

    logic [IDX_BITS-1:0] w_look_idx;
    logic [TAG_BITS-1:0] w_look_tag;
    logic                w_look_hit;

    logic [IDX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_upd_hit;

    logic [XLEN-3:0]     w_pc_next;

    // Byte-offset bits of incoming addresses carry no information.
    logic                w_unused_low_bits;

    assign w_unused_low_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Lookup fields derived from the current fetch PC.
    assign w_look_idx = r_pc[IDX_BITS-1:0];
    assign w_look_tag = r_pc[XLEN-3:IDX_BITS];

    // Update fields derived from the resolved branch PC.
    assign w_upd_idx  = upd_pc_i[IDX_BITS+1:2];
    assign w_upd_tag  = upd_pc_i[XLEN-1:IDX_BITS+2];

    // Combinational BTB lookup; an invalid entry never predicts taken.
    always_comb begin
        w_look_hit    = r_valid[w_look_idx] && (r_tag[w_look_idx] == w_look_tag);
        pred_taken_o  = w_look_hit && r_ctr[w_look_idx][1];
        pred_target_o = {r_target[w_look_idx], 2'b00};
        pc_o          = {r_pc, 2'b00};
    end

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        w_pc_next = r_pc + 1'b1;
        if (redirect_valid_i) begin
            w_pc_next = redirect_pc_i[XLEN-1:2];
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (pred_taken_o) begin
            w_pc_next = r_target[w_look_idx];
        end
    end

    // Hit detection for the update port, evaluated on pre-edge contents.
    always_comb begin
        w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VEC[XLEN-1:2];
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // BTB valid bits and counters: reset clears valid, counters go weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= c_CTR_RESET;
            end
        end else if (upd_valid_i) begin
            if (w_upd_hit) begin
                if (upd_taken_i) begin
                    if (r_ctr[w_upd_idx] != c_CTR_MAX) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
                    end
                end else begin
                    if (r_ctr[w_upd_idx] != c_CTR_MIN) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
                    end
                end
            end else if (upd_taken_i) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= c_CTR_ALLOC;
            end
        end
    end

    // BTB tag/target storage; contents are qualified by valid so no reset needed,
    // but writes are still suppressed during reset so nothing stale is left behind.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid_i && upd_taken_i) begin
            r_target[w_upd_idx] <= upd_target_i[XLEN-1:2];
            if (!w_upd_hit) begin
                r_tag[w_upd_idx] <= w_upd_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_predict.md
Name: pc_predict

Overview:
Parametrised fetch-stage program counter that extends the basic stall-capable PC register. It adds a configurable reset vector, a redirect path that beats stalls, and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it predicts the next fetch address. It sits at the head of the IF stage, drives the instruction-memory address, and takes resolved-branch updates from EX.

Parameters:
XLEN, 32, address/PC width in bits (>= 8)
RESET_VEC, 32'h0000_0000, PC value after reset (bits [1:0] must be 0)
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2
IDX_BITS (localparam), $clog2(BTB_ENTRIES), BTB index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  1  hold current PC (hazard unit stallF)
redirect_valid_i  in  1  force next PC (mispredict/jump resolved in EX)
redirect_pc_i  in  XLEN  redirect target
upd_valid_i  in  1  resolved branch update for BTB
upd_pc_i  in  XLEN  PC of resolved branch
upd_taken_i  in  1  branch actually taken
upd_target_i  in  XLEN  actual branch target
pc_o  out  XLEN  current fetch PC
pred_taken_o  out  1  current PC predicted taken
pred_target_o  out  XLEN  predicted target for current PC (valid when pred_taken_o)

Behaviour:
- State: pc_q; per entry: valid, tag[XLEN-IDX_BITS-3:0], target[XLEN-1:2], ctr[1:0].
- Index = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2]. Bits [1:0] are ignored on every PC input and forced to 0 on pc_o and pred_target_o.
- Reset (posedge clk with rst=1): pc_q <= RESET_VEC, all valid <= 0, all ctr <= 2'b01. Tag/target need no reset. Cycle after reset: pc_o = RESET_VEC, pred_taken_o = 0. Reset overrides every other input, including mid-redirect and mid-update.
- Lookup is combinational on pc_o: hit = valid[idx] && tag match; pred_taken_o = hit && ctr[idx][1]; pred_target_o = {target[idx], 2'b00}.
- Next-PC priority, registered at posedge:
  1. redirect_valid_i -> redirect_pc_i. Applies even when stall_i = 1.
  2. stall_i -> hold pc_q.
  3. pred_taken_o -> pred_target_o.
  4. otherwise pc_q + 4, wrapping modulo 2^XLEN (all-ones-minus-3 wraps to 0).
- Latency: one cycle from redirect/prediction to pc_o.
- BTB update, on posedge when upd_valid_i = 1; independent of stall_i and redirect_valid_i:
  - Entry hit (valid and tag match): ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00). If taken, target <= upd_target_i[XLEN-1:2].
  - Miss and taken: allocate/overwrite: valid <= 1, tag, target, ctr <= 2'b10.
  - Miss and not taken: no change.
- Simultaneous update and lookup of the same entry: lookup uses pre-edge contents; the write takes effect the following cycle.
- No X propagation: pred_taken_o = 0 whenever valid = 0.

Test Plan:
- Reset with RESET_VEC=32'h0000_0100, rst held 2 cycles then released, no other inputs -> pc_o 0x100, 0x104, 0x108, 0x10C; pred_taken_o = 0 throughout.
- stall_i=1 for 3 cycles at pc_o=0x10C, then redirect_valid_i=1 with redirect_pc_i=0x200 while stall still high -> pc_o holds 0x10C for 3 cycles, then 0x200 the cycle after the redirect.
- Update upd_pc=0x208, taken=1, target=0x400; later fetch reaches 0x208 -> pred_taken_o=1, pred_target_o=0x400, next pc_o=0x400 (ctr=10).
- Two not-taken updates to 0x208 -> ctr 10->01->00; fetch at 0x208 gives pred_taken_o=0, next pc_o=0x20C. A third not-taken update keeps ctr at 00.
- Aliasing with BTB_ENTRIES=16: entry for 0x208 taken, then taken update for 0x248 (same index, different tag) -> entry overwritten; fetch at 0x208 gives pred_taken_o=0, fetch at 0x248 predicts the new target.
- Wrap, XLEN=32: redirect to 0xFFFF_FFFC, no BTB hit -> next pc_o = 0x0000_0000. Also assert rst during an active update -> post-reset lookups all miss.
